bus_grant_arbiter: RTL and testbench
====================================

Name: bus_grant_arbiter

Overview:
- Round-robin arbiter that shares one framed bus among N_REQ requesters.
- Issues a one-hot grant and watches the shared frame line.
- Reports aquired when the granted master asserts frame within the timeout window. Reports time_out when it does not, and then reclaims the grant.
- Sits in front of the bus as the sequencer whose req/grant/frame/time_out/aquired behaviour the bus assertions check.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- TIMEOUT, 63, number of cycles after grant rise that the master has to assert frame (2..255).
- CNT_W, 8, width of the wait counter; must hold TIMEOUT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester bus request, level.
- frame  input  1  shared bus frame, driven by the current master.
- grant  output  N_REQ  one-hot grant, registered.
- owner  output  $clog2(N_REQ)  index of the granted requester; valid when grant != 0.
- time_out  output  1  one-cycle pulse: granted master failed to frame within TIMEOUT.
- aquired  output  1  one-cycle pulse: granted master asserted frame within the window.
- to_sticky  output  N_REQ  per-requester sticky timeout flags.
- to_clr  input  1  synchronous clear of to_sticky.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, grant=0, owner=0, wait_cnt=0, rr_ptr=0, to_sticky=0. time_out=0 and aquired=0.
- Reset mid-operation: grant drops immediately and asynchronously; no pulse is generated.
- States: IDLE, WAIT, BUSY, RECOVER.
- IDLE:
  - If any req bit is set, pick the first set bit searching from rr_ptr upward with wrap.
  - Next cycle: grant[w]=1, owner=w, state=WAIT, wait_cnt=0, rr_ptr=(w+1) mod N_REQ.
  - No req: stay in IDLE, grant=0.
- Timing reference: the cycle grant first reads high is t0. wait_cnt=k at t0+k.
- WAIT, evaluated each cycle in priority order:
  1. req[owner]=0: drop grant next cycle and go to IDLE. No pulse.
  2. wait_cnt>=1 and frame=1: aquired=1 combinationally this cycle; state=BUSY next.
  3. wait_cnt==TIMEOUT and frame=0: time_out=1 combinationally this cycle; set to_sticky[owner]; grant=0 next cycle; state=RECOVER.
  4. Otherwise wait_cnt++.
- Frame at t0 (wait_cnt=0) is ignored, so it counts neither as acquire nor as continuation.
- Resulting windows:
  - Frame at t0+1..t0+TIMEOUT gives aquired exactly once.
  - frame=0 for all of t0+1..t0+TIMEOUT gives time_out at t0+TIMEOUT.
  - Frame and the timeout cycle coinciding (frame=1 at wait_cnt==TIMEOUT) gives aquired, not time_out.
- BUSY:
  - Grant is held while frame=1, regardless of req.
  - On the first cycle with frame=0, grant drops next cycle and state=IDLE.
  - No re-grant is issued in the cycle grant drops, so there is at least one idle cycle between tenures.
- RECOVER: exactly one cycle with grant=0, then IDLE. The timed-out requester keeps its rotated-out priority.
- Pulse exclusivity: time_out and aquired are never high together and never outside WAIT. grant is never more than one-hot.
- to_sticky: bits set on time_out. to_clr clears all bits; if a set and to_clr coincide, the set wins.
- Width rules:
  - wait_cnt saturates at TIMEOUT and never wraps.
  - rr_ptr wraps modulo N_REQ (non-power-of-2 N_REQ supported).

Test Plan:
- Single requester, normal: req[0]=1 from cycle 0, grant[0] at cycle 2 (t0), frame=1 at t0+5 → aquired=1 at t0+5 only. Frame low at t0+10 → grant=0 at t0+11.
- Timeout: req[2]=1 held, frame=0 forever → time_out=1 at exactly t0+63 → grant=0 at t0+64, to_sticky=4'b0100, RECOVER, then re-grant of req[2] at t0+66. Then to_clr=1 → to_sticky=0.
- Boundary frame: frame=1 first at t0+63 → aquired=1, time_out=0. Frame=1 only at t0 then low → no aquired, time_out at t0+63.
- Round-robin: req=4'b1111 constantly, each master frames at t0+1 for 2 cycles → grant order 0,1,2,3,0, with one idle cycle between tenures.
- Request withdrawn: req[1] granted, req[1] dropped at t0+10 → grant=0 at t0+11, no time_out, no aquired, to_sticky unchanged.
- Async reset: assert rst_n=0 in the middle of WAIT at wait_cnt=30 → grant=0 immediately. After release, wait_cnt restarts from 0 on the next grant.

Source files
------------

// File: rtl/bus_grant_arbiter.sv
// -----------------------------------------------------------------------------
// bus_grant_arbiter
//
// Round-robin sequencer for a single framed bus shared by N_REQ requesters.
// A one-hot grant is issued to the next requester in rotation. The granted
// master then has TIMEOUT cycles after the grant rises to assert frame.
// If it asserts frame in time, a one-cycle aquired pulse is reported and the
// grant is held for as long as frame stays high. If it misses the window, a
// one-cycle time_out pulse is reported, its sticky flag is set, and the grant
// is reclaimed for one recovery cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester level request             [N_REQ]
//   frame      shared bus frame from the current master
//   grant      registered one-hot grant                 [N_REQ]
//   owner      index of the granted requester           [$clog2(N_REQ)]
//   time_out   one-cycle pulse, master missed the frame window
//   aquired    one-cycle pulse, master framed inside the window
//   to_sticky  per-requester sticky timeout flags       [N_REQ]
//   to_clr     synchronous clear of to_sticky (a coincident set wins)
// -----------------------------------------------------------------------------
module bus_grant_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 63,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic                     frame,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     time_out,
    output logic                     aquired,
    output logic [N_REQ-1:0]         to_sticky,
    input  logic                     to_clr
);

    localparam int OWN_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [N_REQ-1:0]   grant_q,     grant_d;
    logic [OWN_W-1:0]   owner_q,     owner_d;
    logic [CNT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic [OWN_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [N_REQ-1:0]   to_sticky_q, to_sticky_d;

    logic               pick_found_s;
    logic [OWN_W-1:0]   pick_idx_s;
    logic [OWN_W-1:0]   pick_next_s;
    logic               time_out_s;
    logic               aquired_s;

    // Round-robin search: first set req bit at or above rr_ptr, wrapping at N_REQ.
    always_comb begin
        int idx;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        idx          = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            if (!pick_found_s && req[idx]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = OWN_W'(idx);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
        // Explicit wrap so non-power-of-two N_REQ never points past the last requester.
        if (pick_idx_s == OWN_W'(N_REQ - 1)) begin
            pick_next_s = '0;
        end else begin
            pick_next_s = pick_idx_s + OWN_W'(1);
        end
    end

    // Next-state and pulse logic of the grant sequencer.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        wait_cnt_d = wait_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        time_out_s = 1'b0;
        aquired_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    grant_d    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                    owner_d    = pick_idx_s;
                    wait_cnt_d = '0;
                    rr_ptr_d   = pick_next_s;
                    state_d    = ST_WAIT;
                end else begin
                    grant_d = '0;
                end
            end
            ST_WAIT: begin
                if (!req[owner_q]) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if ((wait_cnt_q != '0) && frame) begin
                    // Frame in the grant-rise cycle (wait_cnt == 0) is deliberately ignored.
                    aquired_s = 1'b1;
                    state_d   = ST_BUSY;
                end else if ((wait_cnt_q == CNT_W'(TIMEOUT)) && !frame) begin
                    time_out_s = 1'b1;
                    grant_d    = '0;
                    state_d    = ST_RECOVER;
                end else if (wait_cnt_q != CNT_W'(TIMEOUT)) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end
            ST_BUSY: begin
                // Tenure lasts while frame is high, independent of req.
                if (!frame) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    grant_d = grant_q;
                end
            end
            ST_RECOVER: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky flags: grant_q is the owner's one-hot bit in WAIT, so a set overrides the clear.
    always_comb begin
        if (time_out_s) begin
            to_sticky_d = (to_clr ? '0 : to_sticky_q) | grant_q;
        end else begin
            to_sticky_d = to_clr ? '0 : to_sticky_q;
        end
    end

    // State register; reset drops grant asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            wait_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            to_sticky_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            to_sticky_q <= to_sticky_d;
        end
    end

    assign grant     = grant_q;
    assign owner     = owner_q;
    assign time_out  = time_out_s;
    assign aquired   = aquired_s;
    assign to_sticky = to_sticky_q;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_grant_arbiter
//
// Directed bench for bus_grant_arbiter (N_REQ=4, TIMEOUT=63). A per-cycle
// vector table covers acquire, busy hold, release, rotation and request
// withdrawal; hand-written sequences cover the 63-cycle timeout window,
// its boundaries, the sticky flags, asynchronous reset and full rotation.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// 1 time unit later.
// -----------------------------------------------------------------------------
module tb_bus_grant_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 63;
    localparam int CNT_W   = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       frame;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       time_out;
    logic       aquired;
    logic [3:0] to_sticky;
    logic       to_clr;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] req;
        logic       frame;
        logic [3:0] exp_grant;
        logic [1:0] exp_owner;
        logic       exp_aq;
        logic       exp_to;
    } vec_t;

    vec_t vecs [17];

    bus_grant_arbiter #(
        .N_REQ  (N_REQ),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .frame    (frame),
        .grant    (grant),
        .owner    (owner),
        .time_out (time_out),
        .aquired  (aquired),
        .to_sticky(to_sticky),
        .to_clr   (to_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Move to 1 unit after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously, check the reset state, release after two edges.
    task automatic apply_reset();
        rst_n  = 1'b0;
        req    = 4'b0000;
        frame  = 1'b0;
        to_clr = 1'b0;
        #1;
        chk("rst_grant",     32'(grant),     32'h0);
        chk("rst_owner",     32'(owner),     32'h0);
        chk("rst_time_out",  32'(time_out),  32'h0);
        chk("rst_aquired",   32'(aquired),   32'h0);
        chk("rst_to_sticky", 32'(to_sticky), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 4'b0000;
        frame  = 1'b0;
        to_clr = 1'b0;

        //                req      frm   grant    own    aq    to
        vecs[0]  = '{4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0}; // IDLE picks 0
        vecs[1]  = '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0}; // t0: frame ignored
        vecs[2]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0}; // t0+3 acquire
        vecs[5]  = '{4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0}; // BUSY ignores req
        vecs[6]  = '{4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0}; // frame low: release
        vecs[7]  = '{4'b0011, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0}; // IDLE, ptr=1
        vecs[8]  = '{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0};
        vecs[9]  = '{4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0}; // t0+1 acquire
        vecs[10] = '{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0};
        vecs[11] = '{4'b0011, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0}; // ptr=2 wraps to 0
        vecs[12] = '{4'b0010, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0}; // req0 withdrawn
        vecs[13] = '{4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[14] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0};
        vecs[15] = '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0}; // req1 withdrawn
        vecs[16] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};

        apply_reset();

        // ---- table-driven per-cycle vectors ----
        for (int v = 0; v < 17; v++) begin
            step();
            req   = vecs[v].req;
            frame = vecs[v].frame;
            #1;
            chk("tbl_grant",    32'(grant),    32'(vecs[v].exp_grant));
            chk("tbl_aquired",  32'(aquired),  32'(vecs[v].exp_aq));
            chk("tbl_time_out", 32'(time_out), 32'(vecs[v].exp_to));
            if (vecs[v].exp_grant != 4'b0000) begin
                chk("tbl_owner", 32'(owner), 32'(vecs[v].exp_owner));
            end else begin
                chk("tbl_sticky", 32'(to_sticky), 32'h0);
            end
        end

        // ---- timeout of requester 2, frame never asserted ----
        step();
        req   = 4'b0100;
        frame = 1'b0;
        #1;
        chk("to_idle_grant", 32'(grant), 32'h0);
        for (int k = 0; k <= TIMEOUT; k++) begin
            step();
            #1;
            chk("to_grant_held", 32'(grant),    32'h4);
            chk("to_pulse",      32'(time_out), 32'((k == TIMEOUT) ? 1 : 0));
            chk("to_no_aq",      32'(aquired),  32'h0);
        end
        step();
        #1;
        chk("to_recover_grant", 32'(grant),     32'h0);
        chk("to_sticky_set",    32'(to_sticky), 32'h4);
        chk("to_pulse_once",    32'(time_out),  32'h0);
        step();
        #1;
        chk("to_idle_grant2", 32'(grant), 32'h0);
        step();
        #1;
        chk("to_regrant",       32'(grant), 32'h4);
        chk("to_regrant_owner", 32'(owner), 32'h2);
        req = 4'b0000;
        step();
        #1;
        chk("to_withdraw_grant", 32'(grant),     32'h0);
        chk("to_sticky_kept",    32'(to_sticky), 32'h4);
        to_clr = 1'b1;
        step();
        to_clr = 1'b0;
        #1;
        chk("to_sticky_clr", 32'(to_sticky), 32'h0);

        // ---- boundary: frame first at t0+TIMEOUT gives acquire ----
        req = 4'b0001;
        #1;
        for (int k = 0; k <= TIMEOUT; k++) begin
            step();
            frame = (k == TIMEOUT);
            #1;
            chk("bnd_grant", 32'(grant),    32'h1);
            chk("bnd_aq",    32'(aquired),  32'((k == TIMEOUT) ? 1 : 0));
            chk("bnd_to",    32'(time_out), 32'h0);
        end
        step();
        frame = 1'b0;
        req   = 4'b0000;
        #1;
        chk("bnd_busy_grant", 32'(grant), 32'h1);
        step();
        #1;
        chk("bnd_release",   32'(grant),     32'h0);
        chk("bnd_no_sticky", 32'(to_sticky), 32'h0);

        // ---- boundary: frame only at t0, clear coincides with timeout ----
        req = 4'b0001;
        #1;
        for (int k = 0; k <= TIMEOUT; k++) begin
            step();
            frame  = (k == 0);
            to_clr = (k == TIMEOUT);
            #1;
            chk("t0f_grant", 32'(grant),    32'h1);
            chk("t0f_aq",    32'(aquired),  32'h0);
            chk("t0f_to",    32'(time_out), 32'((k == TIMEOUT) ? 1 : 0));
        end
        step();
        to_clr = 1'b0;
        frame  = 1'b0;
        req    = 4'b0000;
        #1;
        chk("t0f_set_wins", 32'(to_sticky), 32'h1);
        chk("t0f_recover",  32'(grant),     32'h0);
        to_clr = 1'b1;
        step();
        to_clr = 1'b0;
        #1;
        chk("t0f_sticky_clr", 32'(to_sticky), 32'h0);

        // ---- async reset in WAIT at wait_cnt=30, then full window again ----
        req = 4'b0010;
        for (int k = 0; k <= 30; k++) begin
            step();
            #1;
            chk("ar_grant", 32'(grant), 32'h2);
        end
        #2;
        apply_reset();
        req = 4'b0010;
        #1;
        chk("ar_idle_grant", 32'(grant), 32'h0);
        for (int k = 0; k <= TIMEOUT; k++) begin
            step();
            #1;
            chk("ar_grant2", 32'(grant),    32'h2);
            chk("ar_to",     32'(time_out), 32'((k == TIMEOUT) ? 1 : 0));
        end
        step();
        req = 4'b0000;
        #1;
        chk("ar_recover", 32'(grant),     32'h0);
        chk("ar_sticky",  32'(to_sticky), 32'h2);

        // ---- round-robin rotation from a fresh pointer ----
        apply_reset();
        req   = 4'b1111;
        frame = 1'b0;
        #1;
        chk("rr_idle", 32'(grant), 32'h0);
        for (int m = 0; m < 5; m++) begin
            step();
            frame = 1'b0;
            #1;
            chk("rr_grant", 32'(grant), 32'(4'b0001 << (m % 4)));
            chk("rr_owner", 32'(owner), 32'(m % 4));
            step();
            frame = 1'b1;
            #1;
            chk("rr_aq", 32'(aquired), 32'h1);
            step();
            #1;
            chk("rr_busy_aq",    32'(aquired), 32'h0);
            chk("rr_busy_grant", 32'(grant),   32'(4'b0001 << (m % 4)));
            step();
            frame = 1'b0;
            #1;
            chk("rr_drop_grant", 32'(grant), 32'(4'b0001 << (m % 4)));
            step();
            #1;
            chk("rr_gap", 32'(grant), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
